// File: rtl/csa_divider_32.sv
// csa_divider_32: sequential unsigned restoring divider, one quotient bit per
// clock, with the trial subtraction built on a carry-select adder chain.

// csa_adder: carry-select adder built from 4-bit blocks. Each block
// precomputes its sum for carry-in 0 and 1, and the block carries then pick
// the right sum.
module csa_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int BLOCKS = WIDTH / 4;

  logic [BLOCKS-1:0][4:0] blk_sum0;
  logic [BLOCKS-1:0][4:0] blk_sum1;

  genvar g;
  generate
    for (g = 0; g < BLOCKS; g++) begin : g_blk
      assign blk_sum0[g] = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
      assign blk_sum1[g] = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
    end
  endgenerate

  // Ripple the block carries through the select multiplexers.
  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < BLOCKS; i++) begin
      sum[4*i +: 4] = c ? blk_sum1[i][3:0] : blk_sum0[i][3:0];
      c             = c ? blk_sum1[i][4]   : blk_sum0[i][4];
    end
    cout = c;
  end
endmodule

module csa_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  // The restored partial remainder is always below the divisor, so its top
  // bit of the WIDTH+1-bit value is always zero and is not stored.
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    count;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial_low;
  logic             low_carry;
  logic             trial_carry;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (count == CW'(WIDTH - 1));
  assign shifted   = {r_reg, q_reg[WIDTH-1]};

  csa_adder #(.WIDTH(WIDTH)) u_trial_add (
    .a    (shifted[WIDTH-1:0]),
    .b    (~d_reg),
    .cin  (1'b1),
    .sum  (trial_low),
    .cout (low_carry)
  );

  // Top-bit full adder of the trial subtraction: its b input is the
  // complemented zero extension (1), so the carry reduces to a | cin.
  assign trial_carry = shifted[WIDTH] | low_carry;
  assign r_next      = trial_carry ? trial_low : shifted[WIDTH-1:0];
  assign q_next      = {q_reg[WIDTH-2:0], trial_carry};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a start is taken in IDLE and in the DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (divisor == '0) ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN:     if (last_step) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per RUN cycle, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_reg       <= divisor;
      q_reg       <= dividend;
      r_reg       <= '0;
      count       <= '0;
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      q_reg <= q_next;
      r_reg <= r_next;
      count <= count + CW'(1);
      if (last_step) begin
        quotient  <= q_next;
        remainder <= r_next;
      end
    end
  end
endmodule

// File: tb/tb_csa_divider_32.sv
// tb_csa_divider_32: directed and random checks of the sequential divider
// against hand-computed results and the / and % operators.
module tb_csa_divider_32;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  csa_divider_32 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Raise start with operands; the caller's next edge accepts it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Pass the acceptance edge, then follow the run to done and check it.
  // Optionally pulse a stray start at poke_cycle, or chain a new start in
  // the done cycle.
  task automatic runCheck(input string tag, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic exp_dbz,
                          input int exp_lat, input int poke_cycle,
                          input logic [31:0] poke_a, input logic [31:0] poke_b,
                          input bit chain, input logic [31:0] chain_a,
                          input logic [31:0] chain_b);
    int lat;
    int busy_cnt;
    logic busy_at_done;
    bit seen;
    lat = 0;
    busy_cnt = 0;
    busy_at_done = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (done) begin
        seen = 1'b1;
        lat = k;
        busy_at_done = busy;
      end else begin
        if (busy) busy_cnt++;
        if (k == poke_cycle) applyStimulus(poke_a, poke_b);
        else start = 1'b0;
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    checkOutput({tag, " busy_at_done"}, {31'b0, busy_at_done}, 32'd0);
    checkOutput({tag, " quotient"}, quotient, exp_q);
    checkOutput({tag, " remainder"}, remainder, exp_r);
    checkOutput({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
    if (chain) applyStimulus(chain_a, chain_b);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset quotient", quotient, 32'd0);
    checkOutput("reset remainder", remainder, 32'd0);
    checkOutput("reset dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(32'd100, 32'd7);
    runCheck("100/7", 32'd14, 32'd2, 1'b0, 33, 0, '0, '0, 1'b0, '0, '0);

    applyStimulus(32'hFFFF_FFFF, 32'd1);
    runCheck("max/1", 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0, '0, '0, 1'b0, '0, '0);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runCheck("max/max", 32'd1, 32'd0, 1'b0, 33, 0, '0, '0, 1'b0, '0, '0);

    applyStimulus(32'd3, 32'd10);
    runCheck("3/10", 32'd0, 32'd3, 1'b0, 33, 0, '0, '0, 1'b0, '0, '0);

    applyStimulus(32'd5, 32'd0);
    runCheck("5/0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0, '0, '0, 1'b0, '0, '0);

    applyStimulus(32'd1000, 32'd3);
    runCheck("1000/3 poke", 32'd333, 32'd1, 1'b0, 33, 10, 32'd9, 32'd2, 1'b0, '0, '0);

    applyStimulus(32'd50, 32'd5);
    runCheck("50/5", 32'd10, 32'd0, 1'b0, 33, 0, '0, '0, 1'b1, 32'd77, 32'd8);
    runCheck("77/8 b2b", 32'd9, 32'd5, 1'b0, 33, 0, '0, '0, 1'b0, '0, '0);

    // Reset in cycle 15 of a run, with a start raised alongside it.
    @(posedge clk); #1;
    applyStimulus(32'd1000, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(32'd40, 32'd3);
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("midrst busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst done", {31'b0, done}, 32'd0);
    checkOutput("midrst quotient", quotient, 32'd0);
    checkOutput("midrst remainder", remainder, 32'd0);
    checkOutput("midrst dbz", {31'b0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    checkOutput("midrst start ignored busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst start ignored done", {31'b0, done}, 32'd0);

    applyStimulus(32'd20, 32'd6);
    runCheck("20/6", 32'd3, 32'd2, 1'b0, 33, 0, '0, '0, 1'b0, '0, '0);

    // Random operand pairs, divisors spread over all magnitudes.
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      @(posedge clk); #1;
      applyStimulus(ra, rb);
      if (rb == 32'd0)
        runCheck("rand zero", 32'hFFFF_FFFF, ra, 1'b1, 1, 0, '0, '0, 1'b0, '0, '0);
      else
        runCheck("rand", ra / rb, ra % rb, 1'b0, 33, 0, '0, '0, 1'b0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
